// File: rtl/serial_mag_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, result
// encoding and the BitCount width helper.
package comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_GT   = 2'b01,
    RES_EQ   = 2'b10,
    RES_LT   = 2'b11
  } result_t;

  // BitCount must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int bit_count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Operand/result bundle between the operand registers, the comparator and
// whoever consumes the result flags.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
) ();
  import comparator_pkg::*;

  logic                              Start;
  logic [WIDTH-1:0]                  A;
  logic [WIDTH-1:0]                  B;
  logic                              Busy;
  logic                              Done;
  logic                              AGtB;
  logic                              AEqB;
  logic                              ALtB;
  logic [bit_count_width(WIDTH)-1:0] BitCount;

  modport master (
    output Start, A, B,
    input  Busy, Done, AGtB, AEqB, ALtB, BitCount
  );

  modport slave (
    input  Start, A, B,
    output Busy, Done, AGtB, AEqB, ALtB, BitCount
  );

endinterface

// File: rtl/serial_mag_comparator_shift_reg.sv
// WIDTH-bit register with parallel load and zero-fill left shift; exposes
// its MSB so the comparator can walk the operand from the top down.
module cmp_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_d;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with early exit on the first
// differing bit; result flags and BitCount hold until the next accepted Start.
module serial_mag_comparator #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  serial_mag_comparator_if.slave bus
);
  import comparator_pkg::*;

  localparam int               CNT_W   = bit_count_width(WIDTH);
  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state_next;
  result_t          r_result, w_result_next;
  logic [IDX_W-1:0] r_index, w_index_next;
  logic [CNT_W-1:0] r_bit_count, w_bit_count_next;
  logic             w_load, w_shift;
  logic             w_a_msb, w_b_msb;

  cmp_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (bus.A),
    .o_msb   (w_a_msb)
  );

  cmp_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (bus.B),
    .o_msb   (w_b_msb)
  );

  // NOTE: every output of this block gets a default up front so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_next     = r_state;
    w_result_next    = r_result;
    w_index_next     = r_index;
    w_bit_count_next = r_bit_count;
    w_load           = 1'b0;
    w_shift          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_load           = 1'b1;
          w_index_next     = IDX_MSB;
          w_result_next    = RES_NONE;
          w_bit_count_next = '0;
          w_state_next     = S_CMP;
        end
      end

      S_CMP: begin
        w_bit_count_next = r_bit_count + CNT_ONE;
        if (w_a_msb != w_b_msb) begin
          // In two's complement a set sign bit means the smaller operand.
          if (SIGNED && (r_index == IDX_MSB)) begin
            w_result_next = w_a_msb ? RES_LT : RES_GT;
          end else begin
            w_result_next = w_a_msb ? RES_GT : RES_LT;
          end
          w_state_next = S_DONE;
        end else if (r_index == '0) begin
          w_result_next = RES_EQ;
          w_state_next  = S_DONE;
        end else begin
          w_shift      = 1'b1;
          w_index_next = r_index - 1'b1;
        end
      end

      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_result    <= RES_NONE;
      r_index     <= '0;
      r_bit_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_result    <= w_result_next;
      r_index     <= w_index_next;
      r_bit_count <= w_bit_count_next;
    end
  end

  assign bus.Busy     = (r_state == S_CMP);
  assign bus.Done     = (r_state == S_DONE);
  assign bus.AGtB     = (r_result == RES_GT);
  assign bus.AEqB     = (r_result == RES_EQ);
  assign bus.ALtB     = (r_result == RES_LT);
  assign bus.BitCount = r_bit_count;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench: an unsigned and a signed comparator see identical stimulus
// and each is checked against hand-computed flags, BitCount and latency.
module tb_serial_mag_comparator;
  import comparator_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = bit_count_width(WIDTH);

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  serial_mag_comparator_if #(.WIDTH(WIDTH)) u_if ();
  serial_mag_comparator_if #(.WIDTH(WIDTH)) s_if ();

  serial_mag_comparator #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (u_if)
  );

  serial_mag_comparator #(.WIDTH(WIDTH), .SIGNED(1'b1)) s_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (s_if)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    u_if.Start = start;
    s_if.Start = start;
    u_if.A     = a;
    s_if.A     = a;
    u_if.B     = b;
    s_if.B     = b;
  endtask

  function automatic logic [2:0] flags_u();
    return {u_if.AGtB, u_if.AEqB, u_if.ALtB};
  endfunction

  function automatic logic [2:0] flags_s();
    return {s_if.AGtB, s_if.AEqB, s_if.ALtB};
  endfunction

  function automatic logic [3:0] bd_both();
    return {u_if.Busy, s_if.Busy, u_if.Done, s_if.Done};
  endfunction

  task automatic run_vec(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int k, input logic [2:0] exp_u, input logic [2:0] exp_s,
                         input bit hold_start, input bit toggle_a);
    int cycles     = 0;
    bit flags_busy = 1'b0;
    drive(1'b1, a, b);
    step();
    if (!hold_start) drive(1'b0, a, b);
    check({tag, "/busy_start"}, 32'(bd_both()), 32'(4'b1100));
    while (!u_if.Done && cycles < WIDTH + 4) begin
      if ({flags_u(), flags_s()} != 6'b0) flags_busy = 1'b1;
      if (toggle_a) drive(hold_start, ~u_if.A, u_if.B);
      step();
      cycles++;
    end
    check({tag, "/flags_while_busy"}, 32'(flags_busy), 32'(0));
    check({tag, "/latency"}, 32'(cycles), 32'(k));
    check({tag, "/done"}, 32'(bd_both()), 32'(4'b0011));
    check({tag, "/unsigned"}, 32'({flags_u(), u_if.BitCount}), 32'({exp_u, CNT_W'(k)}));
    check({tag, "/signed"}, 32'({flags_s(), s_if.BitCount}), 32'({exp_s, CNT_W'(k)}));
    step();
    if (hold_start) drive(1'b0, a, b);
    check({tag, "/done_pulse"}, 32'(bd_both()), 32'(4'b0000));
    check({tag, "/flags_held"}, 32'({flags_u(), flags_s()}), 32'({exp_u, exp_s}));
    if (hold_start) begin
      step();
      check({tag, "/no_restart"}, 32'(bd_both()), 32'(4'b0000));
    end
  endtask

  initial begin
    bit seen;

    // Reset held for two edges with Start asserted and A=0xFF.
    Rst = 1'b1;
    drive(1'b1, 8'hFF, 8'h00);
    step();
    step();
    check("reset_unsigned", 32'({u_if.Busy, u_if.Done, flags_u(), u_if.BitCount}), 32'(0));
    check("reset_signed", 32'({s_if.Busy, s_if.Done, flags_s(), s_if.BitCount}), 32'(0));
    Rst = 1'b0;
    drive(1'b0, 8'hFF, 8'h00);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (bd_both() != 4'b0) seen = 1'b1;
    end
    check("reset_quiet", 32'(seen), 32'(0));

    run_vec("a5_25", 8'hA5, 8'h25, 1, GT, LT, 1'b0, 1'b0);
    run_vec("10_13", 8'h10, 8'h13, 7, LT, LT, 1'b0, 1'b0);
    repeat (20) step();
    check("hold_20_idle", 32'({flags_u(), u_if.BitCount, flags_s(), s_if.BitCount}),
          32'({LT, CNT_W'(7), LT, CNT_W'(7)}));
    run_vec("3c_3c", 8'h3C, 8'h3C, 8, EQ, EQ, 1'b0, 1'b0);
    run_vec("80_01", 8'h80, 8'h01, 1, GT, LT, 1'b0, 1'b0);
    run_vec("7f_ff", 8'h7F, 8'hFF, 1, LT, GT, 1'b0, 1'b0);
    run_vec("01_00", 8'h01, 8'h00, 8, GT, GT, 1'b0, 1'b0);
    run_vec("fe_ff", 8'hFE, 8'hFF, 8, LT, LT, 1'b0, 1'b0);
    run_vec("hold_toggle", 8'h00, 8'h00, 8, EQ, EQ, 1'b1, 1'b1);

    // Reset at N+3 aborts the compare with no Done and cleared flags.
    drive(1'b1, 8'h00, 8'h00);
    step();
    drive(1'b0, 8'h00, 8'h00);
    step();
    step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("abort_unsigned", 32'({u_if.Busy, u_if.Done, flags_u(), u_if.BitCount}), 32'(0));
    check("abort_signed", 32'({s_if.Busy, s_if.Done, flags_s(), s_if.BitCount}), 32'(0));
    seen = 1'b0;
    repeat (12) begin
      step();
      if (u_if.Done || s_if.Done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'(0));
    run_vec("after_abort", 8'h5A, 8'h5B, 8, LT, LT, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
